// File: rtl/sdram_stream_engine_if.sv
// rtl/sdram_stream_engine_if.sv - request, SDRAM command/data FIFO and read-stream signals of sdram_stream_engine
// Optional: SDRAM_STREAM_STRIDE_EN adds stride_i.
interface sdram_stream_engine_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 16
);
    logic                  start_i;
    logic                  op_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [LEN_WIDTH-1:0]  len_i;
    logic [15:0]           fill_data_i;
`ifdef SDRAM_STREAM_STRIDE_EN
    logic [7:0]            stride_i;
`endif
    logic                  busy_o;
    logic                  done_o;
    logic [40:0]           cmd_d_o;
    logic                  cmd_enq_o;
    logic                  cmd_alm_full_i;
    logic [15:0]           data_q_i;
    logic                  data_deq_o;
    logic                  data_empty_i;
    logic [15:0]           out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;

    modport master (
        input  start_i, op_i, base_addr_i, len_i, fill_data_i,
`ifdef SDRAM_STREAM_STRIDE_EN
        input  stride_i,
`endif
        input  cmd_alm_full_i, data_q_i, data_empty_i, out_ready_i,
        output busy_o, done_o, cmd_d_o, cmd_enq_o, data_deq_o, out_data_o, out_valid_o
    );

    modport slave (
        output start_i, op_i, base_addr_i, len_i, fill_data_i,
`ifdef SDRAM_STREAM_STRIDE_EN
        output stride_i,
`endif
        output cmd_alm_full_i, data_q_i, data_empty_i, out_ready_i,
        input  busy_o, done_o, cmd_d_o, cmd_enq_o, data_deq_o, out_data_o, out_valid_o
    );
endinterface

// File: rtl/sdram_stream_engine.sv
// rtl/sdram_stream_engine.sv - block read/fill command producer and read-data consumer for the SDRAM FIFOs
// Optional: SDRAM_STREAM_STRIDE_EN latches stride_i as the per-command address step (default step 1).
module sdram_stream_engine #(
    parameter int ADDR_WIDTH      = 24,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 512
) (
    input  logic                  clk,
    input  logic                  rst_i,
    sdram_stream_engine_if.master bus
);
    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic                  op_fill;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  received;
    logic [15:0]           fill_data;
    logic [OUT_WIDTH-1:0]  outstanding;
    logic                  read_phase;
    logic                  out_valid;
    logic                  deq;
    logic                  issue_ok;
    logic                  read_enq;

`ifdef SDRAM_STREAM_STRIDE_EN
    logic [7:0] stride;
    assign addr_step = ADDR_WIDTH'(stride);
`else
    assign addr_step = ADDR_WIDTH'(1);
`endif

    // Return path only listens during a read, so stray FIFO words are left alone otherwise.
    assign read_phase = ((state == ISSUE) || (state == DRAIN)) && !op_fill;
    assign out_valid  = read_phase && !bus.data_empty_i;
    assign deq        = out_valid && bus.out_ready_i;

    // Reads are capped by outstanding so the data FIFO can always absorb every reply.
    assign issue_ok = (state == ISSUE) && !bus.cmd_alm_full_i && (issued < len) &&
                      (op_fill || (outstanding < OUT_WIDTH'(MAX_OUTSTANDING)));
    assign read_enq = issue_ok && !op_fill;

    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = bus.data_q_i;
    assign bus.data_deq_o  = deq;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state         <= IDLE;
            op_fill       <= 1'b0;
            addr          <= '0;
            len           <= '0;
            issued        <= '0;
            received      <= '0;
            fill_data     <= '0;
            outstanding   <= '0;
            bus.busy_o    <= 1'b0;
            bus.done_o    <= 1'b0;
            bus.cmd_enq_o <= 1'b0;
            bus.cmd_d_o   <= '0;
`ifdef SDRAM_STREAM_STRIDE_EN
            stride        <= '0;
`endif
        end else begin
            bus.cmd_enq_o <= issue_ok;
            bus.done_o    <= 1'b0;

            if (issue_ok) begin
                bus.cmd_d_o <= {op_fill, addr, op_fill ? fill_data : 16'h0000};
                addr        <= addr + addr_step;
                issued      <= issued + 1'b1;
            end

            if (deq) begin
                received <= received + 1'b1;
            end

            if (read_enq && !deq) begin
                outstanding <= outstanding + 1'b1;
            end else if (deq && !read_enq) begin
                outstanding <= outstanding - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.len_i != '0) begin
                            op_fill     <= bus.op_i;
                            addr        <= bus.base_addr_i;
                            len         <= bus.len_i;
                            fill_data   <= bus.fill_data_i;
`ifdef SDRAM_STREAM_STRIDE_EN
                            stride      <= bus.stride_i;
`endif
                            issued      <= '0;
                            received    <= '0;
                            outstanding <= '0;
                            bus.busy_o  <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            bus.done_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_ok && ((issued + 1'b1) == len)) begin
                        if (op_fill) begin
                            bus.busy_o <= 1'b0;
                            bus.done_o <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (received == len) begin
                        bus.busy_o <= 1'b0;
                        bus.done_o <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
